// File: rtl/ecc_139_scrub_ctrl_if.sv
// Scrubber memory/decoder port bundle.
// master = scrubber, slave = SRAM + ECC decoder side.
interface ecc_139_scrub_ctrl_if #(
  parameter int DATA_WIDTH = 139,
  parameter int ADDR_WIDTH = 8
);
  logic                  mem_rd_en;
  logic                  mem_wr_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] dec_data;
  logic                  dec_sbit_err;
  logic                  dec_dbit_err;
  logic                  dec_ecc_fault;

  modport master (
    output mem_rd_en,
    output mem_wr_en,
    output mem_addr,
    output mem_wdata,
    input  dec_data,
    input  dec_sbit_err,
    input  dec_dbit_err,
    input  dec_ecc_fault
  );

  modport slave (
    input  mem_rd_en,
    input  mem_wr_en,
    input  mem_addr,
    input  mem_wdata,
    output dec_data,
    output dec_sbit_err,
    output dec_dbit_err,
    output dec_ecc_fault
  );
endinterface

// File: rtl/ecc_139_scrub_ctrl.sv
// Background ECC scrubber: walks the FIFO SRAM in idle
// cycles, writes back corrected words, counts/flags errors.
module ecc_139_scrub_ctrl #(
  parameter int DATA_WIDTH   = 139,
  parameter int PARITY_WIDTH = 9,
  parameter int ADDR_WIDTH   = 8,
  parameter int DEPTH        = 256,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_scrub_en,
  input  logic [15:0]           cfg_interval,
  input  logic                  cnt_clr,
  input  logic                  func_req,
  input  logic                  func_wr_en,
  input  logic [ADDR_WIDTH-1:0] func_addr,
  ecc_139_scrub_ctrl_if.master  mem,
  output logic [CNT_WIDTH-1:0]  sbit_cnt,
  output logic [CNT_WIDTH-1:0]  dbit_cnt,
  output logic [CNT_WIDTH-1:0]  fault_cnt,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic                  irq_dbit,
  output logic                  irq_fault,
  output logic                  pass_done,
  output logic                  busy
);

  if (PARITY_WIDTH < 1 || DEPTH < 1 ||
      DEPTH > (1 << ADDR_WIDTH)) begin : g_cfg_err
    $error("ecc_139_scrub_ctrl: bad parameters");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_READ,
    S_CHECK,
    S_WRITE,
    S_NEXT
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] SAT = '1;

  state_t                state;
  state_t                state_nxt;
  logic [ADDR_WIDTH-1:0] scrub_addr;
  logic [15:0]           ivl_cnt;
  logic [DATA_WIDTH-1:0] wb_data;
  logic                  coll;
  logic                  ev_fault;
  logic                  ev_dbit;
  logic                  ev_sbit;

  // A functional write to the word being scrubbed beats us.
  assign coll = func_wr_en &&
                (func_addr == scrub_addr) &&
                (state == S_CHECK || state == S_WRITE);

  // Decoder result, sampled once in CHECK, fault first.
  assign ev_fault = (state == S_CHECK) && mem.dec_ecc_fault;
  assign ev_dbit  = (state == S_CHECK) &&
                    !mem.dec_ecc_fault && mem.dec_dbit_err;
  assign ev_sbit  = (state == S_CHECK) &&
                    !mem.dec_ecc_fault && !mem.dec_dbit_err &&
                    mem.dec_sbit_err;

  assign mem.mem_rd_en = (state == S_READ) && !func_req;
  assign mem.mem_wr_en = (state == S_WRITE) && !func_req &&
                         !coll;
  assign mem.mem_addr  = scrub_addr;
  assign mem.mem_wdata = wb_data;
  assign busy          = (state != S_IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; functional traffic always wins.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (cfg_scrub_en) state_nxt = S_READ;
      end
      S_WAIT: begin
        if (!cfg_scrub_en)          state_nxt = S_IDLE;
        else if (ivl_cnt <= 16'd1)  state_nxt = S_READ;
      end
      S_READ: begin
        if (!cfg_scrub_en)  state_nxt = S_IDLE;
        else if (!func_req) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (ev_sbit && !coll) state_nxt = S_WRITE;
        else                  state_nxt = S_NEXT;
      end
      S_WRITE: begin
        if (coll || !func_req) state_nxt = S_NEXT;
      end
      S_NEXT: begin
        if (cfg_scrub_en && cfg_interval == 16'd0)
          state_nxt = S_READ;
        else
          state_nxt = S_WAIT;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Address walk, idle-gap counter and write-back buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scrub_addr <= '0;
      ivl_cnt    <= '0;
      wb_data    <= '0;
      pass_done  <= 1'b0;
    end else begin
      pass_done <= 1'b0;
      if (ev_sbit) wb_data <= mem.dec_data;
      if (state == S_WAIT && ivl_cnt != 16'd0)
        ivl_cnt <= ivl_cnt - 16'd1;
      if (state == S_NEXT) begin
        ivl_cnt <= cfg_interval;
        if (scrub_addr == LAST) begin
          scrub_addr <= '0;
          pass_done  <= 1'b1;
        end else begin
          scrub_addr <= scrub_addr + 1'b1;
        end
      end
    end
  end

  // Saturating event counters; a clear drops a same-cycle event.
  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      sbit_cnt  <= '0;
      dbit_cnt  <= '0;
      fault_cnt <= '0;
    end else begin
      if (ev_sbit && sbit_cnt != SAT)
        sbit_cnt <= sbit_cnt + 1'b1;
      if (ev_dbit && dbit_cnt != SAT)
        dbit_cnt <= dbit_cnt + 1'b1;
      if (ev_fault && fault_cnt != SAT)
        fault_cnt <= fault_cnt + 1'b1;
    end
  end

  // Sticky interrupts, cleared by the counter clear.
  always_ff @(posedge clk) begin
    if (!rst_n || cnt_clr) begin
      irq_dbit  <= 1'b0;
      irq_fault <= 1'b0;
    end else begin
      if (ev_dbit)  irq_dbit  <= 1'b1;
      if (ev_fault) irq_fault <= 1'b1;
    end
  end

  // Address of the latest uncorrectable event; survives clears.
  always_ff @(posedge clk) begin
    if (!rst_n)                   err_addr <= '0;
    else if (ev_dbit || ev_fault) err_addr <= scrub_addr;
  end

endmodule
